// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the 8-digit seven-segment scanner.
// Holds the scan FSM state encoding, digit geometry and the active-low
// hex-to-segment lookup table used by hex_to_seg.
package seg_pkg;

   typedef enum logic [1:0] {
      SETTLE = 2'd0,
      LATCH  = 2'd1,
      DWELL  = 2'd2,
      ROT    = 2'd3
   } state_t;

   localparam int NUM_DIGITS = 8;
   localparam int DIGIT_W    = 4;
   localparam int IDX_W      = 3;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Segment patterns {g,f,e,d,c,b,a}, active-low, listed from F down to 0
   // so that SEG_TABLE[h] selects the pattern for hex digit h.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'b0001110,   // F
      7'b0000110,   // E
      7'b0100001,   // d
      7'b1000110,   // C
      7'b0000011,   // b
      7'b0001000,   // A
      7'b0010000,   // 9
      7'b0000000,   // 8
      7'b1111000,   // 7
      7'b0000010,   // 6
      7'b0010010,   // 5
      7'b0011001,   // 4
      7'b0110000,   // 3
      7'b0100100,   // 2
      7'b1111001,   // 1
      7'b1000000    // 0
   };

endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: purely combinational 4-bit hex to active-low 7-segment decoder.
module hex_to_seg
   import seg_pkg::*;
(
   input  logic [DIGIT_W-1:0] i_hex,
   output logic [6:0]         o_seg
);

   assign o_seg = SEG_TABLE[i_hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: paces an external 8-digit nibble selector with rotate pulses,
// latches each returned digit after a settle window into a local buffer, and
// scans the buffer onto an active-low 8-anode seven-segment display with a
// blanked gap between digits to avoid ghosting.
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 is always shown).
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int TICK_DIV   = 100000,
   parameter int SETTLE_CYC = 2
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [DIGIT_W-1:0] hex_val,
   output logic               rotate,
   output logic [7:0]         an,
   output logic [6:0]         seg,
   output logic               dp,
   output logic [IDX_W-1:0]   digit_idx
);

   localparam int CNT_MAX = (TICK_DIV > SETTLE_CYC) ? TICK_DIV : SETTLE_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] TICK_LAST   = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

   state_t               r_state;
   state_t               w_stateNext;
   logic [CNT_W-1:0]     r_cnt;
   logic [DIGIT_W-1:0]   r_buf [NUM_DIGITS];
   logic [IDX_W-1:0]     r_digitIdx;
   logic [7:0]           r_an;
   logic [6:0]           r_seg;
   logic                 r_rotate;

   logic                 w_cntDone;
   logic [DIGIT_W-1:0]   w_curDigit;
   logic [6:0]           w_decSeg;
   logic                 w_blank;
   logic [7:0]           w_anNext;
   logic [6:0]           w_segNext;
   logic                 w_rotNext;

   assign w_curDigit = r_buf[r_digitIdx];

   hex_to_seg u_dec (
      .i_hex (w_curDigit),
      .o_seg (w_decSeg)
   );

   // Terminal count for the timed states: settle window or digit dwell.
   assign w_cntDone = ((r_state == SETTLE) && (r_cnt == SETTLE_LAST)) ||
                      ((r_state == DWELL)  && (r_cnt == TICK_LAST));

`ifdef SEG_LEADING_ZERO_BLANK_EN
   // Blank a non-zero-index digit when it and every buffered digit above it are zero.
   always_comb begin
      logic w_upperNonZero;
      w_upperNonZero = 1'b0;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if ((j >= int'(r_digitIdx)) && (r_buf[j] != '0)) begin
            w_upperNonZero = 1'b1;
         end
      end
      w_blank = (r_digitIdx != '0) && !w_upperNonZero;
   end
`else
   assign w_blank = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SETTLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state logic: settle, latch once, dwell, rotate once, repeat.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         SETTLE:  if (w_cntDone) w_stateNext = LATCH;
         LATCH:   w_stateNext = DWELL;
         DWELL:   if (w_cntDone) w_stateNext = ROT;
         ROT:     w_stateNext = SETTLE;
         default: w_stateNext = SETTLE;
      endcase
   end

   // Datapath: shared settle/dwell counter, digit buffer capture and digit index.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= '0;
         r_digitIdx <= '0;
         for (int k = 0; k < NUM_DIGITS; k++) begin
            r_buf[k] <= '0;
         end
      end else begin
         if ((r_state == SETTLE) || (r_state == DWELL)) begin
            r_cnt <= w_cntDone ? '0 : r_cnt + 1'b1;
         end else begin
            r_cnt <= '0;
         end
         if (r_state == LATCH) begin
            r_buf[r_digitIdx] <= hex_val;
         end
         if (r_state == ROT) begin
            r_digitIdx <= r_digitIdx + 1'b1;
         end
      end
   end

   // Output decode: only DWELL lights an anode, only ROT pulses rotate.
   always_comb begin
      w_anNext  = 8'hFF;
      w_segNext = SEG_BLANK;
      w_rotNext = 1'b0;
      case (r_state)
         DWELL: begin
            if (!w_blank) begin
               w_anNext  = ~(8'b1 << r_digitIdx);
               w_segNext = w_decSeg;
            end
         end
         ROT:     w_rotNext = 1'b1;
         default: ;
      endcase
   end

   // Output registers so anodes and segments switch on the same edge, glitch-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_an     <= 8'hFF;
         r_seg    <= SEG_BLANK;
         r_rotate <= 1'b0;
      end else begin
         r_an     <= w_anNext;
         r_seg    <= w_segNext;
         r_rotate <= w_rotNext;
      end
   end

   assign an        = r_an;
   assign seg       = r_seg;
   assign rotate    = r_rotate;
   assign dp        = 1'b1;
   assign digit_idx = r_digitIdx;

endmodule
